// File: rtl/seven_seg_scan.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// Snapshots a 32-bit segment word once per frame and scans it out with a per-slot anode guard.
module seven_seg_scan #(
    parameter int DIGIT_CYCLES = 100000,
    parameter int GUARD_CYCLES = 1000,
    parameter int BLINK_FRAMES = 125
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] seg_word,
    input  logic        blink_en,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_tick
);

    localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] GUARD_END = CW'(GUARD_CYCLES);
    localparam logic [BW-1:0] BCNT_LAST = BW'(BLINK_FRAMES - 1);

    typedef enum logic {
        PH_GUARD,
        PH_ON
    } phase_t;

    logic [CW-1:0] cnt;
    logic [1:0]    dig;
    logic [31:0]   frame;
    logic [BW-1:0] bcnt;
    logic          bphase;
    logic          snap;
    logic [7:0]    cur;
    phase_t        phase;
    logic [3:0]    an_next;
    logic [6:0]    seg_next;
    logic          dp_next;

    assign snap = (dig == 2'd3) && (cnt == CNT_LAST);

    always_comb begin
        cur      = frame[{dig, 3'b000} +: 8];
        phase    = PH_ON;
        an_next  = '1;
        seg_next = '1;
        dp_next  = 1'b1;
        // Blink blanking reuses the guard outputs so anodes never overlap on a transition.
        if ((cnt < GUARD_END) || (blink_en && bphase)) begin
            phase = PH_GUARD;
        end
        if (phase == PH_ON) begin
            an_next  = ~(4'b0001 << dig);
            seg_next = ~cur[6:0];
            dp_next  = ~cur[7];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            dig        <= '0;
            frame      <= '0;
            bcnt       <= '0;
            bphase     <= 1'b0;
            an         <= '1;
            seg        <= '1;
            dp         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                dig <= dig + 2'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            frame_tick <= snap;
            if (snap) begin
                frame <= seg_word;
                if (bcnt == BCNT_LAST) begin
                    bcnt   <= '0;
                    bphase <= ~bphase;
                end else begin
                    bcnt <= bcnt + 1'b1;
                end
            end

            an  <= an_next;
            seg <= seg_next;
            dp  <= dp_next;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Scoreboard bench for seven_seg_scan: the driver queues the expected outputs for each
// cycle from the scan timeline, and a monitor pops and compares one cycle later.
module tb_seven_seg_scan;

    localparam int DC = 8;
    localparam int GC = 2;
    localparam int BF = 2;
    localparam int FRAME = 4 * DC;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       tick;
        int         t;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] seg_word;
    logic        blink_en;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Timeline model: cycles since reset release and the word held in the frame register.
    int          t = 0;
    logic [31:0] frame_m = '0;

    seven_seg_scan #(
        .DIGIT_CYCLES(DC),
        .GUARD_CYCLES(GC),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .seg_word(seg_word),
        .blink_en(blink_en),
        .an(an),
        .seg(seg),
        .dp(dp),
        .frame_tick(frame_tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Push the expected outputs for the next posedge, then advance the model by one cycle.
    task automatic step();
        exp_t       e;
        int         c;
        int         d;
        int         f;
        logic [7:0] b;
        logic       dark;
        e.t = t;
        if (rst) begin
            e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1; e.tick = 1'b0;
            t = 0;
            frame_m = '0;
        end else begin
            c = t % DC;
            d = (t / DC) % 4;
            f = t / FRAME;
            b = frame_m[8*d +: 8];
            dark = (c < GC) || (blink_en && (((f / BF) % 2) == 1));
            e.an   = dark ? 4'hF : ~(4'(1) << d);
            e.seg  = dark ? 7'h7F : ~b[6:0];
            e.dp   = dark ? 1'b1 : ~b[7];
            e.tick = ((t % FRAME) == FRAME - 1);
            if ((t % FRAME) == FRAME - 1) frame_m = seg_word;
            t = t + 1;
        end
        q.push_back(e);
    endtask

    task automatic run(input int n);
        repeat (n) begin
            step();
            @(negedge clk);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                vectors = vectors + 1;
                if (an !== e.an || seg !== e.seg || dp !== e.dp || frame_tick !== e.tick) begin
                    miscompares = miscompares + 1;
                    $display("FAIL scan t=%0d got an=%b seg=%h dp=%b tick=%b want an=%b seg=%h dp=%b tick=%b",
                             e.t, an, seg, dp, frame_tick, e.an, e.seg, e.dp, e.tick);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        seg_word = 32'h3F06_5B4F;
        blink_en = 1'b0;
        @(negedge clk);
        run(3);

        // Frame 0 shows the reset frame, frame 1 the first snapshot.
        rst = 1'b0;
        run(FRAME);
        run(FRAME - 1);
        seg_word = 32'h0000_0080;
        run(1);

        // Frame 2 shows the decimal point word; the change during frame 3 digit 2 waits a frame.
        run(FRAME);
        run(2 * DC);
        seg_word = 32'hFFFF_FFFF;
        run(2 * DC);

        // Frames 4-5 lit, 6-7 dark; blink is released mid-frame 7 during digit 1's ON phase.
        blink_en = 1'b1;
        run(3 * FRAME);
        run(DC + 4);
        blink_en = 1'b0;
        run(FRAME - DC - 4);

        // Reset during digit 2's ON phase must blank the anodes without a clock edge.
        run(2 * DC + 4);
        rst = 1'b1;
        #1;
        vectors = vectors + 1;
        if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || frame_tick !== 1'b0) begin
            miscompares = miscompares + 1;
            $display("FAIL async_reset got an=%b seg=%h dp=%b tick=%b want an=1111 seg=7f dp=1 tick=0",
                     an, seg, dp, frame_tick);
        end
        run(3);
        rst = 1'b0;
        seg_word = 32'h1234_5678;
        run(2 * FRAME + 8);

        @(negedge clk);
        @(negedge clk);
        vectors = vectors + 1;
        if (q.size() != 0) begin
            miscompares = miscompares + 1;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
